// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: main + skid buffer, a registered in_ready, and the architectural flags register.
// Define ALU_WB_PERF_EN to add the retire_cnt/stall_cnt performance counters.
module alu_writeback_stage #(
  parameter int unsigned N            = 4,
  parameter int unsigned RD_W         = 4,
  parameter logic [15:0] FLAG_OP_MASK = 16'h0002
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_result,
  input  logic [1:0]      in_flags,
  input  logic [3:0]      in_select,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wr_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [1:0]      out_flags,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wr_en,
  output logic [1:0]      flags_q
`ifdef ALU_WB_PERF_EN
  ,
  output logic [15:0]     retire_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  // Occupancy of the main/skid pair. A lone entry always lives in main.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state, state_d;

  logic            accept, retire;
  logic            main_from_in, main_from_skid, skid_from_in, flag_upd;

  logic [N-1:0]    main_result, skid_result;
  logic [1:0]      main_flags, skid_flags;
  logic [3:0]      main_select, skid_select;
  logic [RD_W-1:0] main_rd, skid_rd;
  logic            main_wr_en, skid_wr_en;

  // Both ready and valid come straight from the state flops.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  always_comb begin
    state_d        = state;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_from_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (retire && accept) begin
            main_from_in = 1'b1;
          end else if (retire) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_from_in = 1'b1;
            state_d      = FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid-to-main move is possible.
          if (retire) begin
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign flag_upd = retire && !flush && FLAG_OP_MASK[main_select];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Entry payloads only load on a transfer, so outputs hold while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result <= '0;
      main_flags  <= '0;
      main_select <= '0;
      main_rd     <= '0;
      main_wr_en  <= 1'b0;
    end else if (main_from_in) begin
      main_result <= in_result;
      main_flags  <= in_flags;
      main_select <= in_select;
      main_rd     <= in_rd;
      main_wr_en  <= in_wr_en;
    end else if (main_from_skid) begin
      main_result <= skid_result;
      main_flags  <= skid_flags;
      main_select <= skid_select;
      main_rd     <= skid_rd;
      main_wr_en  <= skid_wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result <= '0;
      skid_flags  <= '0;
      skid_select <= '0;
      skid_rd     <= '0;
      skid_wr_en  <= 1'b0;
    end else if (skid_from_in) begin
      skid_result <= in_result;
      skid_flags  <= in_flags;
      skid_select <= in_select;
      skid_rd     <= in_rd;
      skid_wr_en  <= in_wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flag_upd) begin
      flags_q <= main_flags;
    end
  end

  assign out_result = main_result;
  assign out_flags  = main_flags;
  assign out_rd     = main_rd;
  assign out_wr_en  = out_valid && main_wr_en;

`ifdef ALU_WB_PERF_EN
  // A retire squashed by flush does not count; flush never clears the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire && !flush) begin
        retire_cnt <= retire_cnt + 16'd1;
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: FIFO reference model of at most two entries plus the flags-register rule.
module tb_alu_writeback_stage;

  localparam logic [15:0] MASK = 16'h0002;

  typedef struct packed {
    logic [3:0] result;
    logic [1:0] flags;
    logic [3:0] sel;
    logic [3:0] rd;
    logic       wr_en;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic [1:0] in_flags;
  logic [3:0] in_select;
  logic [3:0] in_rd;
  logic       in_wr_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [1:0] out_flags;
  logic [3:0] out_rd;
  logic       out_wr_en;
  logic [1:0] flags_q;
`ifdef ALU_WB_PERF_EN
  logic [15:0] retire_cnt, stall_cnt;
  logic [15:0] exp_retire = '0, exp_stall = '0;
`endif

  int checks = 0;
  int errors = 0;

  ent_t       q[$];
  logic [1:0] mflags = '0;
  logic [3:0] last_result = '0;
  logic [1:0] last_flags = '0;
  logic [3:0] last_rd = '0;

  alu_writeback_stage #(
    .N(4),
    .RD_W(4),
    .FLAG_OP_MASK(16'h0002)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_flags(in_flags),
    .in_select(in_select),
    .in_rd(in_rd),
    .in_wr_en(in_wr_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags),
    .out_rd(out_rd),
    .out_wr_en(out_wr_en),
    .flags_q(flags_q)
`ifdef ALU_WB_PERF_EN
    ,
    .retire_cnt(retire_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state to the model, then advances the model by this cycle's events.
  always @(negedge clk) begin
    ent_t e;
    bit   mretire, maccept;
    if (!rst_n) begin
      q.delete();
      mflags      = '0;
      last_result = '0;
      last_flags  = '0;
      last_rd     = '0;
`ifdef ALU_WB_PERF_EN
      exp_retire = '0;
      exp_stall  = '0;
`endif
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("flags_q", 32'(flags_q), 32'(mflags));
      if (q.size() != 0) begin
        chk("out_result", 32'(out_result), 32'(q[0].result));
        chk("out_flags", 32'(out_flags), 32'(q[0].flags));
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("out_wr_en", 32'(out_wr_en), 32'(q[0].wr_en));
        last_result = q[0].result;
        last_flags  = q[0].flags;
        last_rd     = q[0].rd;
      end else begin
        chk("idle_wr_en", 32'(out_wr_en), 32'd0);
        chk("hold_result", 32'(out_result), 32'(last_result));
        chk("hold_flags", 32'(out_flags), 32'(last_flags));
        chk("hold_rd", 32'(out_rd), 32'(last_rd));
      end
`ifdef ALU_WB_PERF_EN
      chk("retire_cnt", 32'(retire_cnt), 32'(exp_retire));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (q.size() != 0 && !out_ready) exp_stall = exp_stall + 16'd1;
      if (q.size() != 0 && out_ready && !flush) exp_retire = exp_retire + 16'd1;
`endif
      mretire = (q.size() != 0) && out_ready;
      maccept = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (mretire) begin
          e = q.pop_front();
          if (MASK[e.sel]) mflags = e.flags;
        end
        if (maccept) begin
          e.result = in_result;
          e.flags  = in_flags;
          e.sel    = in_select;
          e.rd     = in_rd;
          e.wr_en  = in_wr_en;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] r, input logic [1:0] f, input logic [3:0] s,
                      input logic [3:0] d, input logic w);
    bit acc = 1'b0;
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    in_select = s;
    in_rd     = d;
    in_wr_en  = w;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    in_select = '0;
    in_rd     = '0;
    in_wr_en  = 1'b0;
    out_ready = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags_q", 32'(flags_q), 32'd0);
    tick();

    // Streaming: results 0..7 back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'(i), 2'b00, 4'd2, 4'(i), 1'b1);
    repeat (3) tick();

    // Backpressure
    out_ready = 1'b0;
    send(4'h3, 2'b00, 4'd0, 4'd1, 1'b1);
    send(4'h5, 2'b00, 4'd0, 4'd2, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      tick();
      chk("bp_hold_result", 32'(out_result), 32'h3);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_second_result", 32'(out_result), 32'h5);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flags: compare updates, add does not
    send(4'h1, 2'b10, 4'd1, 4'd3, 1'b0);
    send(4'h2, 2'b01, 4'd2, 4'd4, 1'b1);
    repeat (3) tick();
    chk("flags_after_ops", 32'(flags_q), 32'h2);

    // Flush with a coincident incoming op
    out_ready = 1'b0;
    send(4'h7, 2'b01, 4'd1, 4'd5, 1'b1);
    send(4'h8, 2'b11, 4'd1, 4'd6, 1'b1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 4'h9;
    in_select = 4'd1;
    in_flags  = 2'b11;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_flags_q", 32'(flags_q), 32'h2);
    out_ready = 1'b1;
    tick();
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    send(4'hA, 2'b10, 4'd1, 4'd7, 1'b1);
    send(4'hB, 2'b01, 4'd1, 4'd8, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_wr_en", 32'(out_wr_en), 32'd0);
    chk("async_rst_flags_q", 32'(flags_q), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_result = 4'($urandom);
      in_flags  = 2'($urandom);
      in_select = 4'($urandom_range(0, 3));
      in_rd     = 4'($urandom);
      in_wr_en  = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
